// File: rtl/window_3x3_gen.sv
// -----------------------------------------------------------------------------
// window_3x3_gen
//
// Streaming 3x3 window generator. It takes one pixel per accepted cycle in
// raster order and keeps the two previous rows in line buffers. For every
// stride-aligned position whose full 3x3 neighbourhood is available, it
// presents the neighbourhood on v1..v9 with a one-cycle out_valid strobe.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous frame restart; wins over in_valid (the pixel is dropped)
//   in_valid   in_data is accepted this cycle
//   in_data    pixel at the current (row, col), signed, passed through unmodified
//   out_valid  one-cycle pulse: v1..v9 hold a new window
//   v1..v9     window in row-major order, v1 = (r-2,c-2) ... v9 = (r,c)
//   frame_done one-cycle pulse after the last pixel of a frame is accepted
// -----------------------------------------------------------------------------
module window_3x3_gen #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] v1,
    output logic [DATA_W-1:0] v2,
    output logic [DATA_W-1:0] v3,
    output logic [DATA_W-1:0] v4,
    output logic [DATA_W-1:0] v5,
    output logic [DATA_W-1:0] v6,
    output logic [DATA_W-1:0] v7,
    output logic [DATA_W-1:0] v8,
    output logic [DATA_W-1:0] v9,
    output logic              frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int PH_W  = 2;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_EMIT0 = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_EMIT0 = ROW_W'(2);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(STRIDE - 1);
    localparam logic [PH_W-1:0]  PH_ZERO   = PH_W'(0);

    typedef logic [DATA_W-1:0] word_t;

    // Stride phase of the next position along one axis. Positions below 2
    // never emit, so the position that becomes index 2 always starts at phase 0.
    function automatic logic [PH_W-1:0] ph_next(input logic below_two, input logic [PH_W-1:0] ph);
        logic [PH_W-1:0] nxt;
        if (below_two) begin
            nxt = PH_ZERO;
        end else if (ph == PH_LAST) begin
            nxt = PH_ZERO;
        end else begin
            nxt = ph + PH_W'(1);
        end
        return nxt;
    endfunction

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PH_W-1:0]  cph_q, cph_d;   // (col-2) mod STRIDE for col >= 2
    logic [PH_W-1:0]  rph_q, rph_d;   // (row-2) mod STRIDE for row >= 2
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;

    word_t lb1_q [IMG_W];             // row r-1
    word_t lb2_q [IMG_W];             // row r-2
    word_t win_q [9];                 // internal window, row-major
    word_t win_d [9];
    word_t v_q   [9];                 // output window register
    word_t v_d   [9];

    logic  accept_s;
    logic  emit_s;
    word_t lb1_rd_s;
    word_t lb2_rd_s;

    assign accept_s = in_valid & ~clear;
    assign lb1_rd_s = lb1_q[col_q];
    assign lb2_rd_s = lb2_q[col_q];
    assign emit_s   = accept_s && (row_q >= ROW_EMIT0) && (col_q >= COL_EMIT0) &&
                      (rph_q == PH_ZERO) && (cph_q == PH_ZERO);

    // Next-state: counters, stride phases, window shift and output load
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        cph_d        = cph_q;
        rph_d        = rph_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        for (int k = 0; k < 9; k++) begin
            win_d[k] = win_q[k];
            v_d[k]   = v_q[k];
        end

        if (clear) begin
            col_d = '0;
            row_d = '0;
            cph_d = PH_ZERO;
            rph_d = PH_ZERO;
        end else if (in_valid) begin
            // Shift columns left, load the right column from the buffers and input
            for (int r = 0; r < 3; r++) begin
                win_d[r*3]     = win_q[r*3 + 1];
                win_d[r*3 + 1] = win_q[r*3 + 2];
            end
            win_d[2] = lb2_rd_s;
            win_d[5] = lb1_rd_s;
            win_d[8] = in_data;

            if (emit_s) begin
                out_valid_d = 1'b1;
                for (int k = 0; k < 9; k++) begin
                    v_d[k] = win_d[k];
                end
            end else begin
                out_valid_d = 1'b0;
            end

            if (col_q == COL_LAST) begin
                col_d = '0;
                cph_d = PH_ZERO;
                if (row_q == ROW_LAST) begin
                    row_d        = '0;
                    rph_d        = PH_ZERO;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_W'(1);
                    rph_d = ph_next(row_q < ROW_EMIT0, rph_q);
                end
            end else begin
                col_d = col_q + COL_W'(1);
                cph_d = ph_next(col_q < COL_EMIT0, cph_q);
            end
        end else begin
            out_valid_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    // Control, window and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            cph_q        <= PH_ZERO;
            rph_q        <= PH_ZERO;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
                v_q[k]   <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            cph_q        <= cph_d;
            rph_q        <= rph_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= win_d[k];
                v_q[k]   <= v_d[k];
            end
        end
    end

    // Line buffers: contents need no reset because emission needs two fresh rows
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb2_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= in_data;
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign v1 = v_q[0];
    assign v2 = v_q[1];
    assign v3 = v_q[2];
    assign v4 = v_q[3];
    assign v5 = v_q[4];
    assign v6 = v_q[5];
    assign v7 = v_q[6];
    assign v8 = v_q[7];
    assign v9 = v_q[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;

    typedef logic [8:0][31:0] win_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        iv_a = 1'b0, iv_b = 1'b0, iv_c = 1'b0;
    logic        ov_a, ov_b, ov_c, fd_a, fd_b, fd_c;
    logic [31:0] va [9];
    logic [31:0] vb [9];
    logic [31:0] vc [9];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   fd_cnt_a = 0;
    win_t act_a[$], act_b[$], act_c[$], exp_q[$];
    logic [31:0] stim[$];

    always #5 clk = ~clk;

    window_3x3_gen #(.DATA_W(32), .IMG_W(4), .IMG_H(4), .STRIDE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv_a), .in_data(in_data),
        .out_valid(ov_a), .v1(va[0]), .v2(va[1]), .v3(va[2]), .v4(va[3]), .v5(va[4]),
        .v6(va[5]), .v7(va[6]), .v8(va[7]), .v9(va[8]), .frame_done(fd_a));

    window_3x3_gen #(.DATA_W(32), .IMG_W(5), .IMG_H(5), .STRIDE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv_b), .in_data(in_data),
        .out_valid(ov_b), .v1(vb[0]), .v2(vb[1]), .v3(vb[2]), .v4(vb[3]), .v5(vb[4]),
        .v6(vb[5]), .v7(vb[6]), .v8(vb[7]), .v9(vb[8]), .frame_done(fd_b));

    window_3x3_gen #(.DATA_W(32), .IMG_W(3), .IMG_H(3), .STRIDE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv_c), .in_data(in_data),
        .out_valid(ov_c), .v1(vc[0]), .v2(vc[1]), .v3(vc[2]), .v4(vc[3]), .v5(vc[4]),
        .v6(vc[5]), .v7(vc[6]), .v8(vc[7]), .v9(vc[8]), .frame_done(fd_c));

    // Capture every emitted window, sampled on the falling edge
    always @(negedge clk) begin : mon
        win_t w;
        if (ov_a === 1'b1) begin
            for (int k = 0; k < 9; k++) w[k] = va[k];
            act_a.push_back(w);
        end
        if (ov_b === 1'b1) begin
            for (int k = 0; k < 9; k++) w[k] = vb[k];
            act_b.push_back(w);
        end
        if (ov_c === 1'b1) begin
            for (int k = 0; k < 9; k++) w[k] = vc[k];
            act_c.push_back(w);
        end
        if (fd_a === 1'b1) fd_cnt_a++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted pixel on the selected instance
    task automatic push(input int sel, input logic [31:0] d);
        in_data = d;
        case (sel)
            0: iv_a = 1'b1;
            1: iv_b = 1'b1;
            default: iv_c = 1'b1;
        endcase
        step();
        iv_a = 1'b0;
        iv_b = 1'b0;
        iv_c = 1'b0;
    endtask

    task automatic feed(input int sel, input int gap_max);
        foreach (stim[i]) begin
            push(sel, stim[i]);
            repeat ($urandom_range(gap_max, 0)) step();
        end
        repeat (2) step();
    endtask

    // Reference: enumerate stride-aligned window positions of a w x h frame
    // whose pixels start at stim[base], and append each full neighbourhood.
    task automatic build_exp(input int w, input int h, input int s, input int base);
        win_t x;
        for (int r = 2; r < h; r += s) begin
            for (int c = 2; c < w; c += s) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        x[i*3 + j] = stim[base + (r - 2 + i) * w + (c - 2 + j)];
                exp_q.push_back(x);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_cmp++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b want 0", ov_a); end
        n_cmp++; if (fd_a !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", fd_a); end
        n_cmp++; if (va[0] !== 32'd0) begin n_fail++; $display("FAIL reset_v1: got %h want 0", va[0]); end
        n_cmp++; if (vb[8] !== 32'd0) begin n_fail++; $display("FAIL reset_v9b: got %h want 0", vb[8]); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        win_t got;
        stim.delete(); exp_q.delete(); act_a.delete(); fd_cnt_a = 0;
        for (int i = 0; i < 16; i++) stim.push_back(32'(i));
        build_exp(4, 4, 1, 0);
        for (int i = 0; i < 16; i++) begin
            push(0, stim[i]);
            n_cmp++;
            if (fd_a !== (i == 15)) begin n_fail++; $display("FAIL basic_fd_p%0d: got %b want %b", i, fd_a, (i == 15)); end
        end
        repeat (2) step();
        n_cmp++; if (act_a.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", act_a.size()); end
        n_cmp++; if (fd_cnt_a != 1) begin n_fail++; $display("FAIL basic_fd_count: got %0d want 1", fd_cnt_a); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < act_a.size()) ? act_a[i] : '0;
            n_cmp++;
            if (got !== exp_q[i]) begin n_fail++; $display("FAIL basic_win%0d: got %h want %h", i, got, exp_q[i]); end
        end
        got = (act_a.size() > 0) ? act_a[0] : '0;
        n_cmp++; if (got[4] !== 32'd5 || got[8] !== 32'd10) begin n_fail++; $display("FAIL basic_first: got v5=%0d v9=%0d want 5 10", got[4], got[8]); end
    endtask

    task automatic test_stride();
        win_t got;
        logic [31:0] v9_exp [4];
        v9_exp[0] = 32'd12; v9_exp[1] = 32'd14; v9_exp[2] = 32'd22; v9_exp[3] = 32'd24;
        stim.delete(); exp_q.delete(); act_b.delete();
        for (int i = 0; i < 25; i++) stim.push_back(32'(i));
        build_exp(5, 5, 2, 0);
        feed(1, 0);
        n_cmp++; if (act_b.size() != 4) begin n_fail++; $display("FAIL stride_count: got %0d want 4", act_b.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < act_b.size()) ? act_b[i] : '0;
            n_cmp++;
            if (got !== exp_q[i] || got[8] !== v9_exp[i]) begin n_fail++; $display("FAIL stride_win%0d: got %h want %h", i, got, exp_q[i]); end
        end
        got = (act_b.size() > 0) ? act_b[0] : '0;
        n_cmp++; if (got[0] !== 32'd0 || got[4] !== 32'd6) begin n_fail++; $display("FAIL stride_first: got v1=%0d v5=%0d want 0 6", got[0], got[4]); end
    endtask

    task automatic test_bubbles();
        win_t got, held;
        int k;
        stim.delete(); exp_q.delete(); act_a.delete();
        for (int i = 0; i < 16; i++) stim.push_back(32'(i));
        build_exp(4, 4, 1, 0);
        held = exp_q[exp_q.size() - 1];  // same stream as before: last window still shown
        k = 0;
        for (int p = 0; p < 16; p++) begin
            push(0, stim[p]);
            if (p / 4 >= 2 && p % 4 >= 2) begin held = exp_q[k]; k++; end
            repeat (3) begin
                step();
                n_cmp++;
                if (ov_a !== 1'b0 || va[0] !== held[0] || va[8] !== held[8]) begin
                    n_fail++; $display("FAIL bubble_hold_p%0d: got ov=%b v1=%h v9=%h want 0 %h %h", p, ov_a, va[0], va[8], held[0], held[8]);
                end
            end
        end
        n_cmp++; if (act_a.size() != 4) begin n_fail++; $display("FAIL bubble_count: got %0d want 4", act_a.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < act_a.size()) ? act_a[i] : '0;
            n_cmp++;
            if (got !== exp_q[i]) begin n_fail++; $display("FAIL bubble_win%0d: got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_negative();
        win_t got;
        stim.delete(); act_c.delete();
        for (int i = 0; i < 9; i++) stim.push_back(32'hFFFF_FFFB);
        feed(2, 0);
        n_cmp++; if (act_c.size() != 1) begin n_fail++; $display("FAIL neg_count: got %0d want 1", act_c.size()); end
        got = (act_c.size() > 0) ? act_c[0] : '0;
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (got[k] !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL neg_v%0d: got %h want fffffffb", k + 1, got[k]); end
        end
    endtask

    task automatic test_reset_mid();
        win_t got;
        act_a.delete();
        for (int i = 0; i < 7; i++) push(0, 32'(50 + i));
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (ov_a !== 1'b0 || fd_a !== 1'b0 || va[0] !== 32'd0 || va[8] !== 32'd0) begin
                n_fail++; $display("FAIL rstmid_zero%0d: got ov=%b fd=%b v1=%h v9=%h want all 0", c, ov_a, fd_a, va[0], va[8]);
            end
            step();
        end
        rst_n = 1'b1;
        step();
        stim.delete(); exp_q.delete(); act_a.delete();
        for (int i = 0; i < 16; i++) stim.push_back(32'(100 + i));
        build_exp(4, 4, 1, 0);
        feed(0, 0);
        n_cmp++; if (act_a.size() != 4) begin n_fail++; $display("FAIL rstmid_count: got %0d want 4", act_a.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < act_a.size()) ? act_a[i] : '0;
            n_cmp++;
            if (got !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_win%0d: got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        win_t got;
        stim.delete(); exp_q.delete(); act_a.delete();
        for (int i = 0; i < 32; i++) stim.push_back(32'(i));
        build_exp(4, 4, 1, 0);
        build_exp(4, 4, 1, 16);
        foreach (stim[i]) push(0, stim[i]);
        clear = 1'b1;
        push(0, 32'd999);
        clear = 1'b0;
        n_cmp++; if (ov_a !== 1'b0 || fd_a !== 1'b0) begin n_fail++; $display("FAIL b2b_clear_out: got ov=%b fd=%b want 0 0", ov_a, fd_a); end
        step();
        n_cmp++; if (act_a.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", act_a.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < act_a.size()) ? act_a[i] : '0;
            n_cmp++;
            if (got !== exp_q[i]) begin n_fail++; $display("FAIL b2b_win%0d: got %h want %h", i, got, exp_q[i]); end
        end
        got = (act_a.size() > 4) ? act_a[4] : '0;
        n_cmp++; if (got[0] !== 32'd16) begin n_fail++; $display("FAIL b2b_f2_v1: got %0d want 16", got[0]); end
        // After the dropped pixel the next accepted pixel is (0,0)
        stim.delete(); exp_q.delete(); act_a.delete();
        for (int i = 0; i < 16; i++) stim.push_back(32'(200 + i));
        build_exp(4, 4, 1, 0);
        feed(0, 0);
        n_cmp++; if (act_a.size() != 4) begin n_fail++; $display("FAIL clr_count: got %0d want 4", act_a.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < act_a.size()) ? act_a[i] : '0;
            n_cmp++;
            if (got !== exp_q[i]) begin n_fail++; $display("FAIL clr_win%0d: got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_random();
        win_t got;
        stim.delete(); exp_q.delete(); act_a.delete(); fd_cnt_a = 0;
        for (int i = 0; i < 32; i++) stim.push_back($urandom);
        build_exp(4, 4, 1, 0);
        build_exp(4, 4, 1, 16);
        feed(0, 2);
        n_cmp++; if (act_a.size() != 8) begin n_fail++; $display("FAIL rnd_a_count: got %0d want 8", act_a.size()); end
        n_cmp++; if (fd_cnt_a != 2) begin n_fail++; $display("FAIL rnd_a_fd: got %0d want 2", fd_cnt_a); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < act_a.size()) ? act_a[i] : '0;
            n_cmp++;
            if (got !== exp_q[i]) begin n_fail++; $display("FAIL rnd_a_win%0d: got %h want %h", i, got, exp_q[i]); end
        end
        stim.delete(); exp_q.delete(); act_b.delete();
        for (int i = 0; i < 50; i++) stim.push_back($urandom);
        build_exp(5, 5, 2, 0);
        build_exp(5, 5, 2, 25);
        feed(1, 3);
        n_cmp++; if (act_b.size() != 8) begin n_fail++; $display("FAIL rnd_b_count: got %0d want 8", act_b.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < act_b.size()) ? act_b[i] : '0;
            n_cmp++;
            if (got !== exp_q[i]) begin n_fail++; $display("FAIL rnd_b_win%0d: got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stride();
        test_bubbles();
        test_negative();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
